// File: rtl/sram_arb_ctrl.sv
// Two-port round-robin burst controller for a single-port 128b x 2048 SRAM.
// One requester owns the SRAM per burst; read data returns registered one cycle later.
module sram_arb_ctrl #(
  parameter int DW = 128,
  parameter int AW = 11,
  parameter int LW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      cmd_valid,
  output logic [1:0]      cmd_ready,
  input  logic [1:0]      cmd_we,
  input  logic [2*AW-1:0] cmd_addr,
  input  logic [2*LW-1:0] cmd_len,
  input  logic [1:0]      wvalid,
  output logic [1:0]      wready,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      done,
  output logic            busy,
  output logic            sram_cen,
  output logic            sram_wen,
  output logic            sram_ren,
  output logic [AW-1:0]   sram_a,
  output logic [DW-1:0]   sram_d,
  input  logic [DW-1:0]   sram_q
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q;
  logic            owner_q;
  logic            we_q;
  logic            last_grant_q;
  logic [AW-1:0]   addr_q;
  logic [LW-1:0]   beats_left_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      rvalid_q;
  logic [1:0]      done_q;

  logic            grant_d;
  logic            accept;
  logic            beat;
  logic            last_beat;
  logic [DW-1:0]   owner_wdata;

  // Round-robin: a contested cycle goes to the port that did not win last time.
  always_comb begin
    cmd_ready = 2'b00;
    grant_d   = 1'b0;
    if (state_q == IDLE) begin
      unique case (cmd_valid)
        2'b01:   grant_d = 1'b0;
        2'b10:   grant_d = 1'b1;
        2'b11:   grant_d = ~last_grant_q;
        default: grant_d = 1'b0;
      endcase
      if (cmd_valid != 2'b00) begin
        cmd_ready = grant_d ? 2'b10 : 2'b01;
      end
    end
  end

  assign accept      = (cmd_ready != 2'b00);
  assign owner_wdata = owner_q ? wdata[2*DW-1:DW] : wdata[DW-1:0];
  assign beat        = (state_q == BURST) && (!we_q || (owner_q ? wvalid[1] : wvalid[0]));
  assign last_beat   = beat && (beats_left_q == '0);

  // SRAM pins follow the current beat; a stalled write parks them at the idle values.
  assign sram_cen = ~beat;
  assign sram_wen = beat & we_q;
  assign sram_ren = beat & ~we_q;
  assign sram_a   = beat ? addr_q : '0;
  assign sram_d   = (beat && we_q) ? owner_wdata : '0;
  assign wready   = (beat && we_q) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign done   = done_q;
  assign busy   = (state_q == BURST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      beats_left_q <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 2'b00;
      done_q       <= 2'b00;
    end else begin
      rvalid_q <= 2'b00;
      done_q   <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q      <= grant_d;
            we_q         <= grant_d ? cmd_we[1] : cmd_we[0];
            addr_q       <= grant_d ? cmd_addr[2*AW-1:AW] : cmd_addr[AW-1:0];
            beats_left_q <= grant_d ? cmd_len[2*LW-1:LW] : cmd_len[LW-1:0];
            last_grant_q <= grant_d;
            state_q      <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            addr_q       <= addr_q + 1'b1;
            beats_left_q <= beats_left_q - 1'b1;
            if (!we_q) begin
              rdata_q           <= sram_q;
              rvalid_q[owner_q] <= 1'b1;
            end
            if (last_beat) begin
              state_q         <= IDLE;
              done_q[owner_q] <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scenario bench for sram_arb_ctrl: behavioural SRAM, reference memory and read-data scoreboard.
module tb_sram_arb_ctrl;
  localparam int DW = 128;
  localparam int AW = 11;
  localparam int LW = 8;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } sb_item_t;

  logic            clk;
  logic            reset_n;
  logic [1:0]      cmd_valid;
  logic [1:0]      cmd_ready;
  logic [1:0]      cmd_we;
  logic [2*AW-1:0] cmd_addr;
  logic [2*LW-1:0] cmd_len;
  logic [1:0]      wvalid;
  logic [1:0]      wready;
  logic [2*DW-1:0] wdata;
  logic [1:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic [1:0]      done;
  logic            busy;
  logic            sram_cen;
  logic            sram_wen;
  logic            sram_ren;
  logic [AW-1:0]   sram_a;
  logic [DW-1:0]   sram_d;
  logic [DW-1:0]   sram_q;

  logic [DW-1:0] mem     [2048];
  logic [DW-1:0] ref_mem [2048];
  sb_item_t      sb_q [$];
  int            n_checks;
  int            n_fail;

  sram_arb_ctrl #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rvalid(rvalid), .rdata(rdata), .done(done), .busy(busy),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_cen && sram_wen) mem[sram_a] <= sram_d;
  end
  assign sram_q = mem[sram_a];

  function automatic logic [1:0] pmask(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int p, input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    cmd_we[p] = we;
    cmd_addr[p*AW +: AW] = a;
    cmd_len[p*LW +: LW] = l;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cmd_ready !== 2'b00 || wready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl busy=%b cmd_ready=%b wready=%b required 0/00/00", busy, cmd_ready, wready);
    end
    n_checks++;
    if (rvalid !== 2'b00 || done !== 2'b00 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rd rvalid=%b done=%b rdata=%h required 00/00/0", rvalid, done, rdata);
    end
    n_checks++;
    if (sram_cen !== 1'b1 || sram_wen !== 1'b0 || sram_ren !== 1'b0 || sram_a !== '0 || sram_d !== '0) begin
      n_fail++;
      $display("FAIL reset_pins cen=%b wen=%b ren=%b a=%h d=%h required 1/0/0/0/0",
               sram_cen, sram_wen, sram_ren, sram_a, sram_d);
    end
    step();
    reset_n = 1'b1;
  endtask

  task automatic run_write(input int p, input logic [AW-1:0] addr, input int len,
                           input logic [DW-1:0] d0, input logic [7:0] pat, input int plen);
    logic [1:0]    pm;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          wv;
    int            b;
    int            c;
    pm = pmask(p);
    set_cmd(p, 1'b1, addr, LW'(len));
    cmd_valid[p] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== pm) begin
      n_fail++;
      $display("FAIL wr_accept cmd_ready=%b required %b", cmd_ready, pm);
    end
    step();
    cmd_valid = 2'b00;
    b = 0;
    c = 0;
    while (b <= len && c < 64) begin
      wv = pat[c % plen];
      ed = d0 + DW'(b);
      ea = addr + AW'(b);
      wvalid[p] = wv;
      wdata[p*DW +: DW] = ed;
      @(negedge clk);
      if (wv) begin
        n_checks++;
        if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_a !== ea || sram_d !== ed) begin
          n_fail++;
          $display("FAIL wr_beat%0d cen=%b wen=%b a=%h d=%h required 0/1/%h/%h",
                   b, sram_cen, sram_wen, sram_a, sram_d, ea, ed);
        end
        n_checks++;
        if (wready !== pm) begin
          n_fail++;
          $display("FAIL wr_ready%0d wready=%b required %b", b, wready, pm);
        end
        ref_mem[ea] = ed;
        b++;
      end else begin
        n_checks++;
        if (sram_cen !== 1'b1 || sram_wen !== 1'b0 || wready !== 2'b00) begin
          n_fail++;
          $display("FAIL wr_stall cen=%b wen=%b wready=%b required 1/0/00", sram_cen, sram_wen, wready);
        end
      end
      n_checks++;
      if (busy !== 1'b1 || done !== 2'b00) begin
        n_fail++;
        $display("FAIL wr_busy busy=%b done=%b required 1/00", busy, done);
      end
      step();
      c++;
    end
    wvalid = 2'b00;
    n_checks++;
    if (b <= len) begin
      n_fail++;
      $display("FAIL wr_timeout beats=%0d required %0d", b, len + 1);
    end
    @(negedge clk);
    n_checks++;
    if (done !== pm || busy !== 1'b0 || sram_cen !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_done done=%b busy=%b cen=%b required %b/0/1", done, busy, sram_cen, pm);
    end
    step();
  endtask

  task automatic run_read(input int p, input logic [AW-1:0] addr, input int len);
    logic [1:0]    pm;
    logic [AW-1:0] ea;
    sb_item_t      it;
    pm = pmask(p);
    set_cmd(p, 1'b0, addr, LW'(len));
    cmd_valid[p] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== pm) begin
      n_fail++;
      $display("FAIL rd_accept cmd_ready=%b required %b", cmd_ready, pm);
    end
    step();
    cmd_valid = 2'b00;
    for (int k = 0; k <= len; k++) begin
      ea = addr + AW'(k);
      sb_q.push_back('{port: p, data: ref_mem[ea]});
    end
    for (int c = 0; c <= len + 1; c++) begin
      @(negedge clk);
      if (c <= len) begin
        ea = addr + AW'(c);
        n_checks++;
        if (sram_cen !== 1'b0 || sram_ren !== 1'b1 || sram_wen !== 1'b0 || sram_a !== ea) begin
          n_fail++;
          $display("FAIL rd_beat%0d cen=%b ren=%b wen=%b a=%h required 0/1/0/%h",
                   c, sram_cen, sram_ren, sram_wen, sram_a, ea);
        end
      end else begin
        n_checks++;
        if (sram_cen !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_end cen=%b busy=%b required 1/0", sram_cen, busy);
        end
      end
      if (c == 0) begin
        n_checks++;
        if (rvalid !== 2'b00) begin
          n_fail++;
          $display("FAIL rd_early rvalid=%b required 00", rvalid);
        end
      end else begin
        n_checks++;
        if (rvalid !== pm) begin
          n_fail++;
          $display("FAIL rd_valid%0d rvalid=%b required %b", c - 1, rvalid, pm);
        end
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_sb_empty at beat %0d", c - 1);
        end else begin
          it = sb_q.pop_front();
          if (rdata !== it.data) begin
            n_fail++;
            $display("FAIL rd_data%0d rdata=%h required %h", c - 1, rdata, it.data);
          end
        end
      end
      n_checks++;
      if (done !== ((c == len + 1) ? pm : 2'b00)) begin
        n_fail++;
        $display("FAIL rd_done c=%0d done=%b required %b", c, done, (c == len + 1) ? pm : 2'b00);
      end
      step();
    end
  endtask

  task automatic test_write_burst();
    run_write(0, 11'h010, 3, 128'hA0, 8'b0000_0001, 1);
  endtask

  task automatic test_read_back();
    run_read(1, 11'h010, 3);
  endtask

  task automatic test_write_wrap();
    // pattern bits are consumed LSB first: 1,0,1,1,0,1
    run_write(0, 11'd2046, 3, 128'hB0, 8'b0010_1101, 6);
  endtask

  task automatic test_single_beat();
    run_read(1, 11'h7FF, 0);
  endtask

  task automatic test_back_to_back();
    int       grants;
    int       cyc;
    logic     exp_g;
    logic     g;
    logic     prev_busy;
    sb_item_t it;
    logic [AW-1:0] ba;
    set_cmd(0, 1'b0, 11'h010, 8'd1);
    set_cmd(1, 1'b0, 11'h012, 8'd1);
    cmd_valid = 2'b11;
    grants = 0;
    cyc = 0;
    exp_g = 1'b0;
    prev_busy = 1'b0;
    while ((grants < 4 || sb_q.size() > 0 || busy) && cyc < 60) begin
      @(negedge clk);
      n_checks++;
      if (cmd_ready === 2'b11) begin
        n_fail++;
        $display("FAIL b2b_onehot cmd_ready=%b required at most one bit", cmd_ready);
      end
      if (rvalid !== 2'b00) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_sb_empty rvalid=%b required no data", rvalid);
        end else begin
          it = sb_q.pop_front();
          if (rvalid !== pmask(it.port) || rdata !== it.data) begin
            n_fail++;
            $display("FAIL b2b_rdata rvalid=%b rdata=%h required %b/%h", rvalid, rdata, pmask(it.port), it.data);
          end
        end
      end
      if (cmd_ready !== 2'b00 && grants < 4) begin
        g = cmd_ready[1];
        n_checks++;
        if (g !== exp_g) begin
          n_fail++;
          $display("FAIL b2b_grant%0d port=%0d required %0d", grants, g, exp_g);
        end
        if (grants > 0) begin
          n_checks++;
          if (prev_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap%0d prev_busy=%b required 1", grants, prev_busy);
          end
        end
        ba = g ? 11'h012 : 11'h010;
        sb_q.push_back('{port: int'(g), data: ref_mem[ba]});
        sb_q.push_back('{port: int'(g), data: ref_mem[ba + 11'd1]});
        grants++;
        exp_g = ~exp_g;
      end
      prev_busy = busy;
      step();
      cyc++;
      if (grants == 4) cmd_valid = 2'b00;
    end
    cmd_valid = 2'b00;
    n_checks++;
    if (grants != 4 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_complete grants=%0d pending=%0d required 4/0", grants, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    sb_item_t it;
    set_cmd(0, 1'b0, 11'h010, 8'd15);
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_accept cmd_ready=%b required 01", cmd_ready);
    end
    step();
    cmd_valid = 2'b00;
    repeat (5) step();
    #2;
    n_checks++;
    if (busy !== 1'b1 || rvalid !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_pre busy=%b rvalid=%b required 1/01", busy, rvalid);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (sram_cen !== 1'b1 || sram_ren !== 1'b0 || busy !== 1'b0 || rvalid !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_async cen=%b ren=%b busy=%b rvalid=%b required 1/0/0/00", sram_cen, sram_ren, busy, rvalid);
    end
    @(negedge clk);
    n_checks++;
    if (sram_cen !== 1'b1 || rdata !== '0) begin
      n_fail++;
      $display("FAIL mid_hold cen=%b rdata=%h required 1/0", sram_cen, rdata);
    end
    step();
    reset_n = 1'b1;
    set_cmd(0, 1'b0, 11'h010, 8'd0);
    set_cmd(1, 1'b0, 11'h012, 8'd0);
    cmd_valid = 2'b11;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_rearb cmd_ready=%b required 01", cmd_ready);
    end
    step();
    cmd_valid = 2'b00;
    sb_q.push_back('{port: 0, data: ref_mem[11'h010]});
    step();
    @(negedge clk);
    n_checks++;
    if (rvalid !== 2'b01 || done !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_after rvalid=%b done=%b required 01/01", rvalid, done);
    end
    n_checks++;
    it = sb_q.pop_front();
    if (rdata !== it.data) begin
      n_fail++;
      $display("FAIL mid_rdata rdata=%h required %h", rdata, it.data);
    end
    step();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    cmd_valid = 2'b00;
    cmd_we    = 2'b00;
    cmd_addr  = '0;
    cmd_len   = '0;
    wvalid    = 2'b00;
    wdata     = '0;
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write_burst();
    test_read_back();
    test_write_wrap();
    test_single_beat();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Two-port burst controller and round-robin arbiter for one 128b x 2048 single-port activation/psum SRAM. Each requester, such as the L0 loader or the psum accumulator/readout path, issues a burst command: start address, length and direction. The block grants one requester at a time and sequences the SRAM chip-enable, write-enable, read-enable and address pins beat by beat. Read data is registered and returned to the owning requester. It sits directly between the core datapath and the SRAM macro.

## Interface
- DW, 128, data width (matches the SRAM word)
- AW, 11, SRAM address width (2048 words)
- LW, 8, burst-length field width; a burst is cmd_len+1 beats, so 1..256 beats
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  2  per-port command request; bit i belongs to port i
- cmd_ready  out  2  per-port command accept; at most one bit is high in any cycle
- cmd_we  in  2  per-port direction: 1 = write burst, 0 = read burst
- cmd_addr  in  2*AW  per-port start address; port i occupies bits [i*AW +: AW]
- cmd_len  in  2*LW  per-port beat count minus one; port i occupies bits [i*LW +: LW]
- wvalid  in  2  per-port write-data valid
- wready  out  2  per-port write-beat accept
- wdata  in  2*DW  per-port write data; port i occupies bits [i*DW +: DW]
- rvalid  out  2  per-port read-data valid pulse
- rdata  out  DW  registered read data, shared by both ports and qualified by rvalid
- done  out  2  per-port one-cycle burst-complete pulse
- busy  out  1  high while a burst is in progress
- sram_cen  out  1  SRAM chip enable, active-low
- sram_wen  out  1  SRAM write enable, active-high
- sram_ren  out  1  SRAM read enable, active-high
- sram_a  out  AW  SRAM address
- sram_d  out  DW  SRAM write data
- sram_q  in  DW  SRAM read data; the SRAM returns it combinationally in the same cycle

## Operation
- FSM has two states: IDLE and BURST.
- Registered state: owner, we_q, addr_q, beats_left, last_grant.
- IDLE:
  - The SRAM pins are quiescent: sram_cen=1, sram_wen=0, sram_ren=0, sram_a=0, sram_d=0.
  - cmd_ready is computed combinationally from cmd_valid and last_grant.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port not equal to last_grant is granted.
- On the accepting handshake (cmd_valid[i] & cmd_ready[i]):
  - owner=i, we_q=cmd_we[i], addr_q=cmd_addr[i], beats_left=cmd_len[i], last_grant=i.
  - Next state is BURST.
- BURST, read (we_q=0):
  - A beat is issued every cycle with no stall: sram_cen=0, sram_ren=1, sram_wen=0, sram_a=addr_q.
  - rdata is loaded from sram_q on that edge.
  - rvalid[owner] is high in the following cycle.
- BURST, write (we_q=1):
  - When wvalid[owner]=1: sram_cen=0, sram_wen=1, sram_a=addr_q, sram_d=wdata of owner, and wready[owner]=1 in the same cycle.
  - When wvalid[owner]=0: stall with sram_cen=1, sram_wen=0, and addr_q and beats_left hold.
- On each issued beat, addr_q increments modulo 2^AW, so 2047 wraps to 0; beats_left decrements.
- A beat issued with beats_left=0 is the last beat: next state is IDLE and done[owner] pulses in the next cycle.
- cmd_ready is 0 in BURST. The non-owner port's wready and rvalid stay 0 throughout.
- busy = (state==BURST).

## Timing
- Reset values:
  - state=IDLE, last_grant=1, so port 0 wins the first contest.
  - rdata=0, rvalid=0, done=0, busy=0, cmd_ready=0, wready=0.
  - SRAM pins at their quiescent IDLE values.
- Reset mid-burst: outputs return to reset values immediately and asynchronously. The burst is abandoned and no further SRAM access is made.
- Latency:
  - A command accepted at edge T issues its first beat in cycle T+1.
  - Read beat k is on the SRAM pins in cycle T+1+k, and its rvalid/rdata appear in cycle T+2+k.
- Back-to-back throughput:
  - The earliest next command is accepted in the IDLE cycle after the last-beat cycle.
  - That IDLE cycle is the same cycle as the final rvalid and the done pulse.
  - The minimum gap is one idle SRAM cycle between bursts.
- cmd_valid may drop before it is accepted. cmd_valid on the owner port during BURST is ignored.
- Simultaneous requests arriving while BURST ends are arbitrated in the IDLE cycle using the updated last_grant.

## Test plan
- Reset, then port 0 issues a write burst, addr=0x010, len=3, data 0xA0..0xA3 with wvalid held high. Required: sram_wen=1 for 4 consecutive cycles at sram_a 0x010..0x013, then done[0] one cycle after the last beat.
- Read back the same region on port 1, len=3. Required: rvalid[1] on 4 consecutive cycles with rdata 0xA0..0xA3, the first rvalid two cycles after acceptance, and done[1] coinciding with the last rvalid.
- Write burst at addr=2046, len=3, with wvalid toggling 1,0,1,1,0,1. Required: writes at 2046, 2047, 0, 1 only in the wvalid=1 cycles, and sram_cen=1 during stalls.
- Both ports hold cmd_valid continuously for 4 bursts. Required: grants alternate 0,1,0,1, cmd_ready is never high on both bits at once, and there is exactly one IDLE cycle between bursts.
- Assert reset_n=0 in the middle of a 16-beat read burst. Required: sram_cen=1, busy=0 and rvalid=0 immediately; after release, port 0 wins the next contest.
- Issue a len=0 read burst at addr=0x7FF. Required: a single beat at address 0x7FF, one rvalid, and done asserted in the same cycle as that rvalid.
